// File: rtl/wb_write_arbiter_pkg.sv
// Shared register-file write-port constants for the writeback arbiter and its FIFO.
package wb_write_arbiter_pkg;

    localparam int unsigned REG_DATA_W    = 32;
    localparam int unsigned REG_ADDR_W    = 5;
    localparam int unsigned REG_NUM       = 32;
    localparam int unsigned WB_FIFO_DEPTH = 4;

    localparam logic [REG_DATA_W-1:0] ZERO_WORD = '0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering long-latency {addr, data} results; head is visible combinationally.
module wb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 37,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [W-1:0]     wdata_i,
    input  logic             pop_i,
    output logic [W-1:0]     head_c,
    output logic             full_c,
    output logic             empty_c,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign empty_c = (count_q == '0);
    assign head_c  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Full/empty are start-of-cycle, so a push never lands while full.
    assign push_ok = push_i && !full_c;
    assign pop_ok  = pop_i && !empty_c;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write port arbiter: pipeline writeback has priority over buffered
// long-latency results; tracks outstanding long-latency destinations in pend_mask.
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH  = WB_FIFO_DEPTH,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned NREG   = REG_NUM,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pl_we,
    input  logic [ADDR_W-1:0] pl_waddr,
    input  logic [DATA_W-1:0] pl_wdata,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              ll_valid,
    output logic              ll_ready,
    input  logic [ADDR_W-1:0] ll_waddr,
    input  logic [DATA_W-1:0] ll_wdata,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [NREG-1:0]   pend_mask,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              waw_err
);

    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

    logic [ENTRY_W-1:0] head;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               pl_sel;
    logic               iss_set;
    logic               viol;

    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [NREG-1:0]   pend_q, pend_d;
    logic              waw_q, waw_d;

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (push),
        .wdata_i ({ll_waddr, ll_wdata}),
        .pop_i   (pop),
        .head_c  (head),
        .full_c  (fifo_full),
        .empty_c (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_addr = head[ENTRY_W-1:DATA_W];
    assign head_data = head[DATA_W-1:0];

    assign ll_ready = !fifo_full;
    assign push     = ll_valid && !fifo_full;
    assign pl_sel   = pl_we && (pl_waddr != '0);
    assign pop      = !pl_sel && !fifo_empty;
    assign iss_set  = iss_valid && (iss_addr != '0);

    // Arbitration; a popped register-0 entry is consumed without a write.
    always_comb begin
        rf_we_d    = WRITE_DISABLE;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (pl_sel) begin
            rf_we_d    = WRITE_ENABLE;
            rf_waddr_d = pl_waddr;
            rf_wdata_d = pl_wdata;
        end else if (pop) begin
            rf_we_d    = (head_addr != '0);
            rf_waddr_d = head_addr;
            rf_wdata_d = head_data;
        end
    end

    // Scoreboard: the set is applied after the clear so a newer issue wins.
    always_comb begin
        pend_d = pend_q;
        if (pop && (head_addr != '0)) begin
            pend_d[head_addr] = 1'b0;
        end
        if (iss_set) begin
            pend_d[iss_addr] = 1'b1;
        end
    end

    always_comb begin
        viol = 1'b0;
        if (iss_set && pend_q[iss_addr]) begin
            viol = 1'b1;
        end
        if (pl_sel && pend_q[pl_waddr]) begin
            viol = 1'b1;
        end
        if (push && (ll_waddr != '0) && !pend_q[ll_waddr]) begin
            viol = 1'b1;
        end
        waw_d = waw_q || viol;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we_q    <= WRITE_DISABLE;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            pend_q     <= '0;
            waw_q      <= 1'b0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            pend_q     <= pend_d;
            waw_q      <= waw_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign pend_mask = pend_q;
    assign waw_err   = waw_q;

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writer side of the register file's single write port.
- Merges two write sources into one registered write stream (we/waddr/wdata) that feeds the register file:
  - in-order pipeline writeback, which has priority;
  - long-latency results (divider, load miss), which are buffered in a small FIFO.
- Keeps a scoreboard of registers that have a long-latency result outstanding, so the decode stage can stall on RAW/WAW hazards.

Parameters:
DEPTH, 4, long-latency write FIFO entries (power of 2, >=2)
ADDR_W, 5, register address width
DATA_W, 32, register data width
NREG, 32, number of architectural registers (2**ADDR_W)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (rst==0 resets)
pl_we  in  1  pipeline writeback request, no backpressure
pl_waddr  in  ADDR_W  pipeline destination register
pl_wdata  in  DATA_W  pipeline write data
iss_valid  in  1  long-latency op issued this cycle
iss_addr  in  ADDR_W  destination register of the issued op
ll_valid  in  1  long-latency result valid
ll_ready  out  1  FIFO can accept a result (combinational: !full)
ll_waddr  in  ADDR_W  result destination register
ll_wdata  in  DATA_W  result data
rf_we  out  1  register file write enable (registered)
rf_waddr  out  ADDR_W  register file write address (registered)
rf_wdata  out  DATA_W  register file write data (registered)
pend_mask  out  NREG  scoreboard, bit i = register i has an outstanding long-latency write (registered)
fifo_count  out  log2(DEPTH)+1  current FIFO occupancy
waw_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rst low, asynchronous) clears all outputs and state:
  - rf_we=0, rf_waddr=0, rf_wdata=0;
  - pend_mask=0, FIFO empty, fifo_count=0, waw_err=0;
  - ll_ready=1 once reset is released.
- Reset mid-operation discards all FIFO contents and scoreboard bits. No write is emitted after release until a new request arrives.
- Accept: a long-latency result is accepted on a rising edge when ll_valid && ll_ready. It is pushed into the FIFO with push latency 1.
- Register 0 handling:
  - a write to register 0 never produces rf_we=1;
  - a pipeline write with pl_waddr==0 is ignored;
  - an ll result with ll_waddr==0 is accepted and popped like any other entry, but drives rf_we=0 when selected.
- Output arbitration, evaluated every cycle and registered at the next edge:
  - if pl_we && pl_waddr!=0, emit the pipeline write. Latency is 1 cycle from pl_we to rf_we.
  - otherwise, if the FIFO is non-empty, pop the head and emit it. The emitted entry is the one present at the start of the cycle; a push in the same cycle is never bypassed to the output.
  - otherwise, rf_we=0. rf_waddr and rf_wdata hold their previous values.
- FIFO limits:
  - full: ll_ready=0; ll_valid is held by the source, which is the standard valid/ready rule (source keeps valid and data stable until accepted).
  - simultaneous push and pop when full is legal only if the pop happens. ll_ready uses the start-of-cycle state, so no push is accepted while full.
  - pointers wrap modulo DEPTH; fifo_count is push minus pop.
- Scoreboard:
  - iss_valid && iss_addr!=0 sets pend_mask[iss_addr] at the next edge.
  - emitting a FIFO entry with nonzero address clears pend_mask[addr] at the same edge that rf_we rises.
  - if the set and the clear target the same address in the same cycle, the set wins (the newer op is outstanding).
- Protocol checks, each of which sets waw_err, which then stays set until reset:
  - iss_valid to an address whose pend bit is already set;
  - pl_we to an address whose pend bit is set;
  - ll result accepted for an address whose pend bit is clear (nonzero address).
- These violations change no other behaviour. The decode stage is required to stall using pend_mask.
- Pipeline starvation of the FIFO is permitted; the core's stall controller guarantees bubbles.

Decomposition:
- The shared defines file gains: DATA_W, ADDR_W and NREG equivalents of RegBus, RegAddrBus and RegNum; ZeroWord; WriteEnable/WriteDisable; a new WbFifoDepth constant.
- One sub-module, wb_fifo: synchronous FIFO with async active-low reset, push/pop/full/empty/count. It stores {addr, data} entries of width ADDR_W+DATA_W.
- Arbitration and the scoreboard stay in wb_write_arbiter.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0, and ll_ready=1 after release. Assert rst=0 while 3 FIFO entries are held -> count=0 and pend_mask=0 immediately, with no rf_we afterwards.
- Pipeline only: pl_we=1, waddr=5, wdata=0xDEADBEEF at cycle t -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF at t+1. A pl write to reg 0 -> rf_we stays 0.
- Priority and drain: issue to regs 3,4, then ll results 3=0x11 and 4=0x22 while pl_we is asserted for 4 cycles -> rf shows only pl writes and count=2. When pl drops -> writes 3 then 4 on consecutive cycles, pend_mask bits 3 and 4 clear on those edges.
- Full backpressure: DEPTH=4, pl_we held high, push 4 results -> ll_ready=0. A 5th result held with valid -> not accepted, data unchanged. One pl bubble -> one pop, then ll_ready=1 and the 5th is accepted.
- Set/clear collision: pend bit 7 set, FIFO head is reg 7 being popped in the same cycle as iss_valid to reg 7 -> rf_we to 7 and pend_mask[7] remains 1. waw_err=1 because the issue hit a set bit.
- Violation flags: pl_we to reg 9 while pend_mask[9]=1 -> the write is still emitted and waw_err rises and stays until reset. An ll result for reg 12 with its bit clear -> accepted, written, waw_err=1.
